// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execute unit. Multiplies by shift-add on
//   operand magnitudes, divides by restoring division (one bit per cycle),
//   then applies sign correction and selects the result field. The result is
//   handed back to the register bank through a one-cycle writeback strobe.
//
// Ports
//   clk      in   1     clock, rising edge
//   rst_n    in   1     asynchronous active-low reset
//   start    in   1     request, honoured only while idle and not busy
//   kill     in   1     flush of the in-flight operation (no writeback)
//   op       in   3     funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   rs1_val  in   XLEN  operand A / dividend
//   rs2_val  in   XLEN  operand B / divisor
//   rd_in    in   5     destination register index
//   busy     out  1     operation in flight (through the done cycle)
//   done     out  1     one-cycle completion pulse
//   reg_we   out  1     register-bank write enable (done && rd != 0)
//   rd       out  5     destination register of the completed op
//   rd_val   out  XLEN  result, held until the next completion
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic            reg_we,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_val
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN-1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Two's-complement negation of an XLEN-wide value.
  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a double-width product.
  function automatic logic [2*XLEN-1:0] neg2_f(input logic [2*XLEN-1:0] v);
    return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t            state_r, state_s;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        op_r;
  logic [4:0]        rd_lat_r;
  logic              sa_r, sb_r, dz_r, ov_r;
  logic [XLEN-1:0]   a_r, b_r, hi_r, lo_r, res_r;

  logic              a_sgn_s, b_sgn_s, dz_in_s, ov_in_s, accept_s;
  logic [XLEN-1:0]   a_abs_s, b_abs_s;
  logic [XLEN:0]     sum_s, rsh_s, diff_s;
  logic [XLEN-1:0]   nhi_s, nlo_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;
  logic [XLEN-1:0]   quo_s, rem_s, dividend_s, result_s;

  // Request decode: per-op operand signedness, magnitudes and special cases.
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (op)
      3'b001, 3'b100, 3'b110: begin
        a_sgn_s = rs1_val[XLEN-1];
        b_sgn_s = rs2_val[XLEN-1];
      end
      3'b010: begin
        a_sgn_s = rs1_val[XLEN-1];
        b_sgn_s = 1'b0;
      end
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
    endcase
    a_abs_s  = a_sgn_s ? neg_f(rs1_val) : rs1_val;
    b_abs_s  = b_sgn_s ? neg_f(rs2_val) : rs2_val;
    dz_in_s  = op[2] && (rs2_val == ZERO);
    // Only the signed divide ops (op[0]==0) can overflow.
    ov_in_s  = op[2] && !op[0] && (rs1_val == MIN_INT) && (rs2_val == ONES);
    // busy is still high in the done cycle, so a start there is not taken.
    accept_s = (state_r == S_IDLE) && !busy && start;
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(XLEN+1){1'b0}});
    rsh_s  = {hi_r, lo_r[XLEN-1]};
    diff_s = rsh_s - {1'b0, b_r};
    if (op_r[2]) begin
      if (!diff_s[XLEN]) begin
        nhi_s = diff_s[XLEN-1:0];
        nlo_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        nhi_s = rsh_s[XLEN-1:0];
        nlo_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      // Product shifts right one place, carry enters the top of hi.
      nhi_s = sum_s[XLEN:1];
      nlo_s = {sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Sign correction and result-field selection.
  always_comb begin
    prod_s     = {hi_r, lo_r};
    prod_fix_s = (sa_r ^ sb_r) ? neg2_f(prod_s) : prod_s;
    dividend_s = sa_r ? neg_f(a_r) : a_r;
    if (dz_r) begin
      quo_s = ONES;
      rem_s = dividend_s;
    end else if (ov_r) begin
      quo_s = MIN_INT;
      rem_s = ZERO;
    end else begin
      quo_s = (sa_r ^ sb_r) ? neg_f(lo_r) : lo_r;
      rem_s = sa_r ? neg_f(hi_r) : hi_r;
    end
    case ({op_r[2], op_r[1:0] == 2'b00, op_r[1]})
      3'b010, 3'b011: result_s = prod_fix_s[XLEN-1:0];
      3'b000, 3'b001: result_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b110: result_s = quo_s;
      3'b101, 3'b111: result_s = rem_s;
      default:        result_s = ZERO;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = (EARLY_OUT && (dz_in_s || ov_in_s)) ? S_FIX : S_CALC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (kill) begin
          state_s = S_IDLE;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = S_FIX;
        end else begin
          state_s = S_CALC;
        end
      end
      S_FIX: begin
        if (kill) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Datapath registers and the registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= CNT_ZERO;
      op_r     <= 3'b000;
      rd_lat_r <= 5'd0;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      dz_r     <= 1'b0;
      ov_r     <= 1'b0;
      a_r      <= ZERO;
      b_r      <= ZERO;
      hi_r     <= ZERO;
      lo_r     <= ZERO;
      res_r    <= ZERO;
      busy     <= 1'b0;
      done     <= 1'b0;
      reg_we   <= 1'b0;
      rd       <= 5'd0;
      rd_val   <= ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          done   <= 1'b0;
          reg_we <= 1'b0;
          if (accept_s) begin
            op_r     <= op;
            rd_lat_r <= rd_in;
            sa_r     <= a_sgn_s;
            sb_r     <= b_sgn_s;
            dz_r     <= dz_in_s;
            ov_r     <= ov_in_s;
            a_r      <= a_abs_s;
            b_r      <= b_abs_s;
            hi_r     <= ZERO;
            // lo holds the multiplier, or the dividend being shifted out.
            lo_r     <= op[2] ? a_abs_s : b_abs_s;
            cnt_r    <= CNT_INIT;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        S_CALC: begin
          if (kill) begin
            busy <= 1'b0;
          end else begin
            hi_r  <= nhi_s;
            lo_r  <= nlo_s;
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        S_FIX: begin
          if (kill) begin
            busy <= 1'b0;
          end else begin
            res_r <= result_s;
          end
        end
        S_DONE: begin
          if (kill) begin
            busy <= 1'b0;
          end else begin
            done   <= 1'b1;
            reg_we <= (rd_lat_r != 5'd0);
            rd     <= rd_lat_r;
            rd_val <= res_r;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit: stimulus pushes the hand-computed
//   expected writeback into a queue, a monitor pops and compares on each done.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs1_val = 32'd0;
  logic [31:0] rs2_val = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done, reg_we;
  logic [4:0]  rd;
  logic [31:0] rd_val;

  typedef struct {
    logic [31:0] val;
    logic [4:0]  rd;
    logic        we;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          done_cnt = 0;
  logic [31:0] last_val = 32'd0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .reg_we(reg_we), .rd(rd), .rd_val(rd_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rd_val", rd_val, mon_e.val);
        chk("rd", {27'd0, rd}, {27'd0, mon_e.rd});
        chk("reg_we", {31'd0, reg_we}, {31'd0, mon_e.we});
        chk("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  // Present a request at a negedge and let the next posedge accept it.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] ev, input int lat,
                        input int poke_at);
    exp_t e;
    bit dropped = 1'b0;
    bit seen = 1'b0;
    launch(o, a, b, r);
    e.val = ev; e.rd = r; e.we = (r != 5'd0); e.lat = lat; e.acc = cyc;
    sb_q.push_back(e);
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (i == poke_at) begin
        // A start while busy: different op and rd, must be ignored.
        start = 1'b1; op = MUL; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
      end
      if (!busy) dropped = 1'b1;
      if (done) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_held", {31'd0, dropped}, 32'd0);
    last_val = ev;
    @(negedge clk);
    chk("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_reg_we"}, {31'd0, reg_we}, 32'd0);
    chk({tag, "_rd"}, {27'd0, rd}, 32'd0);
    chk({tag, "_rd_val"}, rd_val, 32'd0);
  endtask

  initial begin
    int dc;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34, -1);
    run_op(MULH,   32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 34, -1);
    run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 34, -1);
    run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 34, -1);
    run_op(DIV,    32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 34, -1);
    run_op(REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 34, -1);
    run_op(DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       34, -1);
    run_op(REMU,   32'd100,      32'd7,        5'd8,  32'd2,        34, -1);
    run_op(DIV,    32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 2,  -1);
    run_op(REM,    32'd5,        32'd0,        5'd10, 32'd5,        2,  -1);
    run_op(REM,    32'hFFFFFFF9, 32'd0,        5'd11, 32'hFFFFFFF9, 2,  -1);
    run_op(DIVU,   32'hFFFFFFF9, 32'd0,        5'd12, 32'hFFFFFFFF, 2,  -1);
    run_op(DIV,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 2,  -1);
    run_op(REM,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        2,  -1);

    // Kill ten cycles into a divide: no writeback, result unchanged.
    dc = done_cnt;
    launch(DIV, 32'd100, 32'd7, 5'd15);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("kill_no_done", done_cnt - dc, 32'd0);
    chk("kill_rd_val", rd_val, last_val);
    run_op(MUL, 32'd3, 32'd4, 5'd16, 32'd12, 34, -1);

    // Reset dropped mid-operation: outputs return to zero at once.
    dc = done_cnt;
    launch(DIV, 32'd100, 32'd7, 5'd17);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset_no_done", done_cnt - dc, 32'd0);
    chk_outputs_zero("post_reset");
    run_op(MUL, 32'd3, 32'd4, 5'd18, 32'd12, 34, -1);

    // rd=0 suppresses reg_we; a start pulsed while busy is ignored.
    dc = done_cnt;
    run_op(MUL, 32'd2, 32'd2, 5'd0, 32'd4, 34, 5);
    repeat (40) @(negedge clk);
    chk("ignored_start_one_done", done_cnt - dc, 32'd1);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
